data_path: RTL and testbench
============================

Name: data_path

Overview:
- 32-bit single-bus Mini SRC processor datapath: R0–R15, HI, LO, PC, IR, MAR, MDR, Y, 64-bit Z (ZHI/ZLO), ALU, IR-field select/encode logic and CON branch flip-flop.
- All register traffic goes over one internal 32-bit bus.
- The external control unit (or bench) drives every strobe. Memory data enters on Mdatain.

Parameters:
- none. Width is fixed at 32 bits; the register index is 4 bits.

Ports:
- clk  input  1  clock; all registers update on the rising edge
- clr  input  1  reset; asynchronous, active-low; clears every register
- alu_control  input  5  ALU operation select
- Mdatain  input  32  memory read data
- R0out..R15out  input  1 each  drive Rn onto the bus
- MDROut, HIout, LOout, ZHIout, ZLOout, Pout, Cout, Yout  input  1 each  drive MDR / HI / LO / Z[63:32] / Z[31:0] / PC / C_sext / Y onto the bus
- IRen, MARen, MDRen, Yen, Pen, ZHIen, ZLOen, HIen, LOen  input  1 each  register load enables
- Read  input  1  MDR input-mux select (1 = Mdatain, 0 = bus)
- Write  input  1  memory write strobe; exported unchanged on mem_write; no internal effect
- R0en..R15en  input  1 each  explicit load enable for Rn
- Gra, Grb, Grc  input  1 each  select IR field ra / rb / rc
- BAout, ConIn, Rin, Rout  input  1 each  base-address out; CON latch enable; encoded register load; encoded register drive
- bus_out  output  32  current bus value
- mar_out  output  32  MAR contents
- mdr_out  output  32  MDR contents
- mem_write  output  1  equals Write
- con_out  output  1  CON flip-flop

Behaviour:
- Reset: while clr=0, all registers, Z and CON are 0.
- Bus mux (combinational):
  - Priority order: R0..R15 (explicit or encoded), HI, LO, ZHI, ZLO, PC, MDR, C_sext, Y.
  - When no source is asserted, the bus is 0.
  - A register driven via BAout reads as 0 when it is R0.
- Select/encode:
  - ra=IR[26:23], rb=IR[22:19], rc=IR[18:15].
  - idx = (Gra?ra:0) | (Grb?rb:0) | (Grc?rc:0).
  - Rin loads R[idx]. Rout or BAout drives R[idx].
  - Explicit Rnen/Rnout are ORed with the decoded strobes.
- C_sext is IR[18:0] sign-extended to 32 bits.
- Registers:
  - Each register loads the bus on its enable.
  - MDR loads Read ? Mdatain : bus.
  - Z loads the ALU result per half: ZHIen loads [63:32], ZLOen loads [31:0].
- ALU operands: A=Y, B=bus. Result is 64 bits; the upper half is 0 except for MUL and DIV.
- ALU opcodes:
  - 00000 ADD, 00001 SUB, 00010 AND, 00011 OR
  - 00100 SHR (logical), 00101 SHRA (arithmetic), 00110 SHL, 00111 ROR, 01000 ROL — shift/rotate amount is B[4:0]
  - 01001 MUL: signed 64-bit product
  - 01010 DIV: signed; quotient in the low half, remainder in the high half
  - 01011 NEG (−B), 01100 NOT (~B), 01101 INC (B+1)
  - any other opcode: result 0
- Divide by zero: quotient 0xFFFFFFFF, remainder A.
- Arithmetic is 32-bit wrap; no flags.
- CON: when ConIn=1, latches condition C2=IR[20:19] evaluated on the bus:
  - 00: bus==0
  - 01: bus!=0
  - 10: bus[31]==0
  - 11: bus[31]==1
- Simultaneous enables to the same register: the single bus value is loaded (no conflict).

Optional Feature:
- Macro DATAPATH_DIV_EN.
- Defined: the divider is built as specified.
- Undefined: DIV returns 0 in both Z halves and no divider logic is synthesized.

Decomposition:
- Shared package datapath_pkg holds:
  - ALU opcode localparams
  - IR field bit positions
  - C2 condition codes
- One sub-module, datapath_alu: combinational A, B, alu_control → 64-bit result.

Test Plan:
1. clr low mid-run → bus_out, mar_out, mdr_out and con_out all 0 immediately.
2. Fetch: PC=0; Pout+MARen → mar_out=0; Read+MDRen with Mdatain=0x0A000000 → mdr_out=0x0A000000; MDROut+IRen → IR loaded; then Gra+Rout → bus_out = R4 (ra=4).
3. R2=0x7, Y loaded from R2, R3=0x5 on bus, alu 00000 with ZLOen → ZLOout gives 0xC; alu 00001 → 0x2.
4. Y=0xFFFFFFFE, B=3, MUL with ZHIen+ZLOen → ZHI=0xFFFFFFFF, ZLO=0xFFFFFFFA. DIV with Y=17, B=5 → ZLO=3, ZHI=2. DIV with B=0 → ZLO=0xFFFFFFFF, ZHI=17.
5. IR[18:0]=0x7FFFF with Cout → bus 0xFFFFFFFF. BAout selecting R0 (R0=0x55) → bus 0.
6. IR[20:19]=00, R5=0 on bus, ConIn → con_out=1. Repeat with R5=1 → con_out=0.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared constants for the Mini SRC single-bus datapath: widths, ALU opcodes,
// IR field positions and branch condition codes.
package datapath_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned NUM_REGS   = 16;
  localparam int unsigned ALU_OP_W   = 5;
  localparam int unsigned SHAMT_W    = 5;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 5'b00000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 5'b00001;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 5'b00010;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 5'b00011;
  localparam logic [ALU_OP_W-1:0] ALU_SHR  = 5'b00100;
  localparam logic [ALU_OP_W-1:0] ALU_SHRA = 5'b00101;
  localparam logic [ALU_OP_W-1:0] ALU_SHL  = 5'b00110;
  localparam logic [ALU_OP_W-1:0] ALU_ROR  = 5'b00111;
  localparam logic [ALU_OP_W-1:0] ALU_ROL  = 5'b01000;
  localparam logic [ALU_OP_W-1:0] ALU_MUL  = 5'b01001;
  localparam logic [ALU_OP_W-1:0] ALU_DIV  = 5'b01010;
  localparam logic [ALU_OP_W-1:0] ALU_NEG  = 5'b01011;
  localparam logic [ALU_OP_W-1:0] ALU_NOT  = 5'b01100;
  localparam logic [ALU_OP_W-1:0] ALU_INC  = 5'b01101;

  localparam int unsigned IR_RA_LSB  = 23;
  localparam int unsigned IR_RB_LSB  = 19;
  localparam int unsigned IR_RC_LSB  = 15;
  localparam int unsigned IR_C2_LSB  = 19;
  localparam int unsigned C2_W       = 2;
  localparam int unsigned IR_CONST_W = 19;

  localparam logic [C2_W-1:0] C2_ZERO    = 2'b00;
  localparam logic [C2_W-1:0] C2_NONZERO = 2'b01;
  localparam logic [C2_W-1:0] C2_POS     = 2'b10;
  localparam logic [C2_W-1:0] C2_NEG     = 2'b11;

  // Immediate field of the IR, sign-extended to bus width.
  function automatic logic [DATA_W-1:0] c_sext(input logic [DATA_W-1:0] ir);
    return {{(DATA_W-IR_CONST_W){ir[IR_CONST_W-1]}}, ir[IR_CONST_W-1:0]};
  endfunction

endpackage

// File: rtl/data_path_if.sv
// Control strobes and observation outputs between the control unit (master)
// and the datapath (slave). Bit n of reg_out/reg_en is Rnout/Rnen.
interface data_path_if;
  import datapath_pkg::*;

  logic [ALU_OP_W-1:0] alu_control;
  logic [DATA_W-1:0]   Mdatain;
  logic [NUM_REGS-1:0] reg_out;
  logic [NUM_REGS-1:0] reg_en;
  logic MDROut, HIout, LOout, ZHIout, ZLOout, Pout, Cout, Yout;
  logic IRen, MARen, MDRen, Yen, Pen, ZHIen, ZLOen, HIen, LOen;
  logic Read, Write;
  logic Gra, Grb, Grc, BAout, ConIn, Rin, Rout;

  logic [DATA_W-1:0]   bus_out;
  logic [DATA_W-1:0]   mar_out;
  logic [DATA_W-1:0]   mdr_out;
  logic                mem_write;
  logic                con_out;

  modport master (
    output alu_control, Mdatain, reg_out, reg_en,
           MDROut, HIout, LOout, ZHIout, ZLOout, Pout, Cout, Yout,
           IRen, MARen, MDRen, Yen, Pen, ZHIen, ZLOen, HIen, LOen,
           Read, Write, Gra, Grb, Grc, BAout, ConIn, Rin, Rout,
    input  bus_out, mar_out, mdr_out, mem_write, con_out
  );

  modport slave (
    input  alu_control, Mdatain, reg_out, reg_en,
           MDROut, HIout, LOout, ZHIout, ZLOout, Pout, Cout, Yout,
           IRen, MARen, MDRen, Yen, Pen, ZHIen, ZLOen, HIen, LOen,
           Read, Write, Gra, Grb, Grc, BAout, ConIn, Rin, Rout,
    output bus_out, mar_out, mdr_out, mem_write, con_out
  );

endinterface

// File: rtl/datapath_alu.sv
// Combinational 64-bit-result ALU, A=Y and B=bus. The signed divider is only
// built when DATAPATH_DIV_EN is defined; otherwise DIV yields 0.
module datapath_alu
  import datapath_pkg::*;
(
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [ALU_OP_W-1:0] alu_control,
  output logic [2*DATA_W-1:0] result
);

  logic [SHAMT_W-1:0]  sh;
  logic [2*DATA_W-1:0] a_sx, b_sx, mul_c, ror_full, rol_full;

  assign sh       = b[SHAMT_W-1:0];
  assign a_sx     = {{DATA_W{a[DATA_W-1]}}, a};
  assign b_sx     = {{DATA_W{b[DATA_W-1]}}, b};
  assign mul_c    = a_sx * b_sx;
  // Rotates via a doubled operand so a zero amount needs no special case.
  assign ror_full = {a, a} >> sh;
  assign rol_full = {a, a} << sh;

`ifdef DATAPATH_DIV_EN
  logic [DATA_W-1:0] quo_c, rem_c;

  // Zero divisor and the single overflow case are pinned explicitly.
  always_comb begin
    quo_c = '0;
    rem_c = '0;
    if (b == '0) begin
      quo_c = '1;
      rem_c = a;
    end else if (a == {1'b1, {(DATA_W-1){1'b0}}} && b == '1) begin
      quo_c = a;
      rem_c = '0;
    end else begin
      quo_c = DATA_W'($signed(a) / $signed(b));
      rem_c = DATA_W'($signed(a) % $signed(b));
    end
  end
`endif

  always_comb begin
    result = '0;
    case (alu_control)
      ALU_ADD:  result = {{DATA_W{1'b0}}, a + b};
      ALU_SUB:  result = {{DATA_W{1'b0}}, a - b};
      ALU_AND:  result = {{DATA_W{1'b0}}, a & b};
      ALU_OR:   result = {{DATA_W{1'b0}}, a | b};
      ALU_SHR:  result = {{DATA_W{1'b0}}, a >> sh};
      ALU_SHRA: result = {{DATA_W{1'b0}}, DATA_W'($signed(a) >>> sh)};
      ALU_SHL:  result = {{DATA_W{1'b0}}, a << sh};
      ALU_ROR:  result = {{DATA_W{1'b0}}, ror_full[DATA_W-1:0]};
      ALU_ROL:  result = {{DATA_W{1'b0}}, rol_full[2*DATA_W-1:DATA_W]};
      ALU_MUL:  result = mul_c;
`ifdef DATAPATH_DIV_EN
      ALU_DIV:  result = {rem_c, quo_c};
`endif
      ALU_NEG:  result = {{DATA_W{1'b0}}, DATA_W'(0) - b};
      ALU_NOT:  result = {{DATA_W{1'b0}}, ~b};
      ALU_INC:  result = {{DATA_W{1'b0}}, b + DATA_W'(1)};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/data_path.sv
// Mini SRC single-bus datapath: register file, special registers, bus mux,
// IR select/encode, CON flip-flop. DIV hardware depends on DATAPATH_DIV_EN.
module data_path
  import datapath_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  data_path_if.slave ctl
);

  logic [DATA_W-1:0]   r [NUM_REGS];
  logic [DATA_W-1:0]   hi, lo, pc, ir, mar, mdr, y;
  logic [2*DATA_W-1:0] z, alu_res;
  logic                con;

  logic [DATA_W-1:0]   bus_c;
  logic [IDX_W-1:0]    idx_c;
  logic [NUM_REGS-1:0] dec_c, r_in_c, r_drive_c;
  logic                ba_r0_c, found_c, cond_c;
  logic                unused_ir_op;

  assign unused_ir_op = ^ir[DATA_W-1:IR_RA_LSB+IDX_W];

  // IR register-field select/encode, merged with the explicit strobes.
  assign idx_c     = (ctl.Gra ? ir[IR_RA_LSB +: IDX_W] : '0)
                   | (ctl.Grb ? ir[IR_RB_LSB +: IDX_W] : '0)
                   | (ctl.Grc ? ir[IR_RC_LSB +: IDX_W] : '0);
  assign dec_c     = NUM_REGS'(1) << idx_c;
  assign r_in_c    = ctl.reg_en  | (ctl.Rin ? dec_c : '0);
  assign r_drive_c = ctl.reg_out | ((ctl.Rout | ctl.BAout) ? dec_c : '0);
  assign ba_r0_c   = ctl.BAout & (idx_c == '0) & ~ctl.reg_out[0];

  // Priority bus mux; lowest-numbered GPR wins, then the special registers.
  always_comb begin
    bus_c   = '0;
    found_c = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!found_c && r_drive_c[i]) begin
        bus_c   = (i == 0 && ba_r0_c) ? '0 : r[i];
        found_c = 1'b1;
      end
    end
    if (!found_c) begin
      if      (ctl.HIout)  bus_c = hi;
      else if (ctl.LOout)  bus_c = lo;
      else if (ctl.ZHIout) bus_c = z[2*DATA_W-1:DATA_W];
      else if (ctl.ZLOout) bus_c = z[DATA_W-1:0];
      else if (ctl.Pout)   bus_c = pc;
      else if (ctl.MDROut) bus_c = mdr;
      else if (ctl.Cout)   bus_c = c_sext(ir);
      else if (ctl.Yout)   bus_c = y;
    end
  end

  always_comb begin
    cond_c = 1'b0;
    case (ir[IR_C2_LSB +: C2_W])
      C2_ZERO:    cond_c = (bus_c == '0);
      C2_NONZERO: cond_c = (bus_c != '0);
      C2_POS:     cond_c = ~bus_c[DATA_W-1];
      C2_NEG:     cond_c = bus_c[DATA_W-1];
      default:    cond_c = 1'b0;
    endcase
  end

  datapath_alu u_alu (
    .a           (y),
    .b           (bus_c),
    .alu_control (ctl.alu_control),
    .result      (alu_res)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NUM_REGS; i++) r[i] <= '0;
      hi  <= '0;
      lo  <= '0;
      pc  <= '0;
      ir  <= '0;
      mar <= '0;
      mdr <= '0;
      y   <= '0;
      z   <= '0;
      con <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (r_in_c[i]) r[i] <= bus_c;
      end
      if (ctl.HIen)  hi  <= bus_c;
      if (ctl.LOen)  lo  <= bus_c;
      if (ctl.Pen)   pc  <= bus_c;
      if (ctl.IRen)  ir  <= bus_c;
      if (ctl.MARen) mar <= bus_c;
      if (ctl.Yen)   y   <= bus_c;
      if (ctl.MDRen) mdr <= ctl.Read ? ctl.Mdatain : bus_c;
      if (ctl.ZHIen) z[2*DATA_W-1:DATA_W] <= alu_res[2*DATA_W-1:DATA_W];
      if (ctl.ZLOen) z[DATA_W-1:0]        <= alu_res[DATA_W-1:0];
      if (ctl.ConIn) con <= cond_c;
    end
  end

  assign ctl.bus_out   = bus_c;
  assign ctl.mar_out   = mar;
  assign ctl.mdr_out   = mdr;
  assign ctl.mem_write = ctl.Write;
  assign ctl.con_out   = con;

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: fetch, ALU ops, IR select/encode, CON and reset.
module tb_data_path;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  data_path_if dp ();

  data_path u_dut (
    .clk (clk),
    .clr (clr),
    .ctl (dp.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    dp.alu_control = '0; dp.Mdatain = '0; dp.reg_out = '0; dp.reg_en = '0;
    dp.MDROut = 0; dp.HIout = 0; dp.LOout = 0; dp.ZHIout = 0; dp.ZLOout = 0;
    dp.Pout = 0; dp.Cout = 0; dp.Yout = 0;
    dp.IRen = 0; dp.MARen = 0; dp.MDRen = 0; dp.Yen = 0; dp.Pen = 0;
    dp.ZHIen = 0; dp.ZLOen = 0; dp.HIen = 0; dp.LOen = 0;
    dp.Read = 0; dp.Write = 0;
    dp.Gra = 0; dp.Grb = 0; dp.Grc = 0; dp.BAout = 0; dp.ConIn = 0;
    dp.Rin = 0; dp.Rout = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic mdr_load(input logic [31:0] v);
    dp.Read = 1; dp.MDRen = 1; dp.Mdatain = v;
    tick();
  endtask

  task automatic set_reg(input int n, input logic [31:0] v);
    mdr_load(v);
    dp.MDROut = 1; dp.reg_en[n] = 1'b1;
    tick();
  endtask

  task automatic load_ir(input logic [31:0] v);
    mdr_load(v);
    dp.MDROut = 1; dp.IRen = 1;
    tick();
  endtask

  task automatic load_y(input logic [31:0] v);
    mdr_load(v);
    dp.MDROut = 1; dp.Yen = 1;
    tick();
  endtask

  task automatic alu_b(input logic [4:0] op, input logic [31:0] b);
    mdr_load(b);
    dp.MDROut = 1; dp.alu_control = op; dp.ZHIen = 1; dp.ZLOen = 1;
    tick();
  endtask

  task automatic read_z(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    dp.ZHIout = 1; #1;
    check({tag, " zhi"}, dp.bus_out, exp_hi);
    idle();
    dp.ZLOout = 1; #1;
    check({tag, " zlo"}, dp.bus_out, exp_lo);
    idle();
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst mar", dp.mar_out, 32'h0);
    check("rst mdr", dp.mdr_out, 32'h0);
    check("rst con", 32'(dp.con_out), 32'h0);
    check("rst bus idle", dp.bus_out, 32'h0);
    @(negedge clk);
    clr = 1'b1;
    #1;

    // Fetch
    set_reg(4, 32'h1234_5678);
    dp.Pout = 1; dp.MARen = 1;
    tick();
    check("fetch mar", dp.mar_out, 32'h0);
    mdr_load(32'h0A00_0000);
    check("fetch mdr", dp.mdr_out, 32'h0A00_0000);
    dp.MDROut = 1; dp.IRen = 1;
    tick();
    dp.Gra = 1; dp.Rout = 1; #1;
    check("gra rout r4", dp.bus_out, 32'h1234_5678);
    idle();

    // ADD / SUB via R2, R3
    set_reg(2, 32'h7);
    dp.reg_out[2] = 1; dp.Yen = 1;
    tick();
    set_reg(3, 32'h5);
    dp.reg_out[3] = 1; dp.alu_control = 5'b00000; dp.ZLOen = 1;
    tick();
    dp.ZLOout = 1; #1;
    check("add zlo", dp.bus_out, 32'hC);
    idle();
    dp.reg_out[3] = 1; dp.alu_control = 5'b00001; dp.ZLOen = 1;
    tick();
    dp.ZLOout = 1; #1;
    check("sub zlo", dp.bus_out, 32'h2);
    idle();

    // Logic, shifts, rotates (Y = 7 still)
    alu_b(5'b00010, 32'h5);          read_z("and", 32'h0, 32'h5);
    alu_b(5'b00011, 32'h8);          read_z("or",  32'h0, 32'hF);
    alu_b(5'b00110, 32'h5);          read_z("shl", 32'h0, 32'hE0);
    alu_b(5'b00111, 32'h1);          read_z("ror", 32'h0, 32'h8000_0003);
    load_y(32'h8000_0000);
    alu_b(5'b00101, 32'h4);          read_z("shra", 32'h0, 32'hF800_0000);
    alu_b(5'b00100, 32'h4);          read_z("shr",  32'h0, 32'h0800_0000);
    load_y(32'h8000_0001);
    alu_b(5'b01000, 32'h1);          read_z("rol", 32'h0, 32'h0000_0003);

    // MUL, DIV
    load_y(32'hFFFF_FFFE);
    alu_b(5'b01001, 32'h3);          read_z("mul", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    load_y(32'd17);
    alu_b(5'b01010, 32'h5);
`ifdef DATAPATH_DIV_EN
    read_z("div", 32'h2, 32'h3);
`else
    read_z("div", 32'h0, 32'h0);
`endif
    alu_b(5'b01010, 32'h0);
`ifdef DATAPATH_DIV_EN
    read_z("div0", 32'd17, 32'hFFFF_FFFF);
`else
    read_z("div0", 32'h0, 32'h0);
`endif
    alu_b(5'b01011, 32'h5);          read_z("neg", 32'h0, 32'hFFFF_FFFB);
    alu_b(5'b01100, 32'h0);          read_z("not", 32'h0, 32'hFFFF_FFFF);
    alu_b(5'b01101, 32'hFFFF_FFFF);  read_z("inc", 32'h0, 32'h0);
    alu_b(5'b11111, 32'h5);          read_z("badop", 32'h0, 32'h0);

    // C_sext and BAout on R0
    set_reg(0, 32'h55);
    load_ir(32'h0007_FFFF);
    dp.Cout = 1; #1;
    check("csext neg", dp.bus_out, 32'hFFFF_FFFF);
    idle();
    dp.Gra = 1; dp.BAout = 1; #1;
    check("baout r0", dp.bus_out, 32'h0);
    idle();
    dp.Gra = 1; dp.Rout = 1; #1;
    check("rout r0", dp.bus_out, 32'h55);
    idle();

    // CON with C2 = 00 (IR still 0x0007FFFF)
    set_reg(5, 32'h0);
    dp.reg_out[5] = 1; dp.ConIn = 1;
    tick();
    check("con eq0 true", 32'(dp.con_out), 32'h1);
    set_reg(5, 32'h1);
    dp.reg_out[5] = 1; dp.ConIn = 1;
    tick();
    check("con eq0 false", 32'(dp.con_out), 32'h0);

    // C2 = 11, rb = 3 decode, Rin, priority, mem_write
    load_ir(32'h0018_0000);
    dp.Cout = 1; #1;
    check("csext pos", dp.bus_out, 32'h0000_0000);
    idle();
    set_reg(6, 32'h8000_0000);
    dp.reg_out[6] = 1; dp.ConIn = 1;
    tick();
    check("con neg", 32'(dp.con_out), 32'h1);
    dp.Grb = 1; dp.Rout = 1; #1;
    check("grb rout r3", dp.bus_out, 32'h5);
    idle();
    mdr_load(32'hA5A5_A5A5);
    dp.MDROut = 1; dp.Grb = 1; dp.Rin = 1;
    tick();
    dp.reg_out[3] = 1; dp.HIout = 1; #1;
    check("rin r3 prio", dp.bus_out, 32'hA5A5_A5A5);
    idle();
    dp.Write = 1; #1;
    check("mem_write", 32'(dp.mem_write), 32'h1);
    idle();

    // Asynchronous clear mid-run
    mdr_load(32'hDEAD_BEEF);
    dp.MDROut = 1; dp.MARen = 1;
    tick();
    check("mar load", dp.mar_out, 32'hDEAD_BEEF);
    @(negedge clk);
    dp.reg_out[3] = 1;
    clr = 1'b0;
    #1;
    check("clr mar", dp.mar_out, 32'h0);
    check("clr mdr", dp.mdr_out, 32'h0);
    check("clr con", 32'(dp.con_out), 32'h0);
    check("clr bus r3", dp.bus_out, 32'h0);
    idle();
    @(negedge clk);
    clr = 1'b1;
    set_reg(9, 32'h0BAD_F00D);
    dp.reg_out[9] = 1; #1;
    check("post clr r9", dp.bus_out, 32'h0BAD_F00D);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
